// File: rtl/muldiv_unit.sv
// Iterative multiply/divide execution unit: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, sign fix-up at the end, start/busy/done handshake.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            zero_division,
    output logic            overflow_signed_div
);

    localparam int CNT_W = $clog2(XLEN + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_op;
    logic              r_neg, r_fast, r_zdiv_p, r_ovf_p;
    logic              r_busy, r_done, r_zdiv, r_ovf;
    logic [XLEN-1:0]   r_mc, r_result;
    logic [2*XLEN-1:0] r_acc;

    logic              w_accept, w_a_sgn, w_b_sgn, w_neg, w_zdiv, w_ovf, w_fast, w_busy_nxt;
    logic [XLEN-1:0]   w_ma, w_mb, w_q, w_r, w_fin;
    logic [XLEN:0]     w_sum, w_shl, w_diff;
    logic [2*XLEN-1:0] w_step, w_prod;

    // Operand decode: acceptance, signedness, magnitudes and fast-path detection.
    always_comb begin
        w_accept = start & ~flush & ((r_state == S_IDLE) | (r_state == S_DONE));
        if (funct3[2]) begin
            w_a_sgn = a[XLEN-1] & ~funct3[0];
            w_b_sgn = b[XLEN-1] & ~funct3[0];
        end else begin
            w_a_sgn = a[XLEN-1] & (funct3[1:0] != 2'b11);
            w_b_sgn = b[XLEN-1] & ~funct3[1];
        end
        w_ma   = w_a_sgn ? ({XLEN{1'b0}} - a) : a;
        w_mb   = w_b_sgn ? ({XLEN{1'b0}} - b) : b;
        // Remainders take the dividend's sign; products and quotients the XOR.
        w_neg  = (funct3[2] & funct3[1]) ? w_a_sgn : (w_a_sgn ^ w_b_sgn);
        w_zdiv = funct3[2] & (b == {XLEN{1'b0}});
        w_ovf  = funct3[2] & ~funct3[0] & (a == {1'b1, {(XLEN-1){1'b0}}}) &
                 (b == {XLEN{1'b1}});
        w_fast = w_zdiv | w_ovf;
    end

    // One radix-2 iteration and the final sign fix-up / result selection.
    always_comb begin
        w_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} +
                 (r_acc[0] ? {1'b0, r_mc} : {(XLEN+1){1'b0}});
        w_shl  = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
        w_diff = w_shl - {1'b0, r_mc};
        if (r_op[2]) begin
            if (w_diff[XLEN]) begin
                w_step = {w_shl[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
            end else begin
                w_step = {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
            end
        end else begin
            w_step = {w_sum, r_acc[XLEN-1:1]};
        end
        w_prod = r_neg ? ({(2*XLEN){1'b0}} - r_acc) : r_acc;
        w_q    = r_neg ? ({XLEN{1'b0}} - r_acc[XLEN-1:0]) : r_acc[XLEN-1:0];
        w_r    = r_neg ? ({XLEN{1'b0}} - r_acc[2*XLEN-1:XLEN]) : r_acc[2*XLEN-1:XLEN];
        if (r_fast) begin
            if (r_zdiv_p) begin
                w_fin = r_op[1] ? r_acc[XLEN-1:0] : {XLEN{1'b1}};
            end else begin
                w_fin = r_op[1] ? {XLEN{1'b0}} : r_acc[XLEN-1:0];
            end
        end else begin
            case (r_op)
                3'b000:                 w_fin = w_prod[XLEN-1:0];
                3'b001, 3'b010, 3'b011: w_fin = w_prod[2*XLEN-1:XLEN];
                3'b100, 3'b101:         w_fin = w_q;
                default:                w_fin = w_r;
            endcase
        end
    end

    // Next-state logic; flush outranks both start and normal progress.
    always_comb begin
        w_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_accept) begin
                    w_nxt = w_fast ? S_FIN : S_RUN;
                end else begin
                    w_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                if (flush) begin
                    w_nxt = S_IDLE;
                end else if (r_cnt == {CNT_W{1'b0}}) begin
                    w_nxt = S_FIN;
                end else begin
                    w_nxt = S_RUN;
                end
            end
            S_FIN: begin
                if (flush) begin
                    w_nxt = S_IDLE;
                end else begin
                    w_nxt = S_DONE;
                end
            end
            default: w_nxt = S_IDLE;
        endcase
        // Fast-path operations pass through FIN without stalling the pipeline.
        w_busy_nxt = (w_nxt == S_RUN) |
                     ((w_nxt == S_FIN) & ~(w_accept ? w_fast : r_fast));
    end

    // State register and registered handshake outputs.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= (w_nxt == S_DONE);
        end
    end

    // Datapath: operand capture, iteration, and result/flag registration.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_cnt    <= {CNT_W{1'b0}};
            r_op     <= 3'b000;
            r_neg    <= 1'b0;
            r_fast   <= 1'b0;
            r_zdiv_p <= 1'b0;
            r_ovf_p  <= 1'b0;
            r_mc     <= {XLEN{1'b0}};
            r_acc    <= {(2*XLEN){1'b0}};
            r_result <= {XLEN{1'b0}};
            r_zdiv   <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (w_accept) begin
            r_op     <= funct3;
            r_neg    <= w_neg;
            r_fast   <= w_fast;
            r_zdiv_p <= w_zdiv;
            r_ovf_p  <= w_ovf & ~w_zdiv;
            r_cnt    <= w_fast ? {CNT_W{1'b0}} : CNT_W'(XLEN);
            r_mc     <= funct3[2] ? w_mb : w_ma;
            if (w_fast) begin
                r_acc <= {{XLEN{1'b0}}, a};
            end else begin
                r_acc <= {{XLEN{1'b0}}, (funct3[2] ? w_ma : w_mb)};
            end
        end else if ((r_state == S_RUN) && !flush && (r_cnt != {CNT_W{1'b0}})) begin
            r_acc <= w_step;
            r_cnt <= r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
        end else if ((r_state == S_FIN) && !flush) begin
            r_result <= w_fin;
            r_zdiv   <= r_zdiv_p;
            r_ovf    <= r_ovf_p;
        end
    end

    assign busy                = r_busy;
    assign done                = r_done;
    assign result              = r_result;
    assign zero_division       = r_zdiv;
    assign overflow_signed_div = r_ovf;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table at XLEN=32, flush/reset sequences,
// and a short XLEN=16 back-to-back check.
module tb_muldiv_unit;

    logic CLK = 1'b0;
    logic RESET;
    always #5 CLK = ~CLK;

    logic        start, flush, busy, done, zero_division, overflow_signed_div;
    logic [2:0]  funct3;
    logic [31:0] a, b, result;

    logic        h_start, h_flush, h_busy, h_done, h_zd, h_ov;
    logic [2:0]  h_funct3;
    logic [15:0] h_a, h_b, h_result;

    muldiv_unit #(.XLEN(32)) dut (
        .CLK(CLK), .RESET(RESET), .start(start), .funct3(funct3), .a(a), .b(b),
        .flush(flush), .busy(busy), .done(done), .result(result),
        .zero_division(zero_division), .overflow_signed_div(overflow_signed_div)
    );

    muldiv_unit #(.XLEN(16)) dut16 (
        .CLK(CLK), .RESET(RESET), .start(h_start), .funct3(h_funct3), .a(h_a), .b(h_b),
        .flush(h_flush), .busy(h_busy), .done(h_done), .result(h_result),
        .zero_division(h_zd), .overflow_signed_div(h_ov)
    );

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a, b, res;
        logic        zd, ov;
        int          lat;
    } vec_t;

    vec_t vq[$];
    int   total = 0;
    int   bad   = 0;

    function automatic vec_t mk(input logic [2:0] f, input logic [31:0] ia, ib, r,
                                input logic zd, ov, input int l);
        vec_t v;
        v.f = f; v.a = ia; v.b = ib; v.res = r; v.zd = zd; v.ov = ov; v.lat = l;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Issue one op from an idle/done cycle, then scramble inputs and wait for done.
    task automatic run32(input logic [2:0] f, input logic [31:0] ia, ib,
                         output int lat, output int bc);
        start = 1'b1; funct3 = f; a = ia; b = ib;
        @(posedge CLK); #1;
        start = 1'b0; funct3 = ~f; a = $urandom; b = $urandom;
        lat = 0; bc = 0;
        while (!done && lat < 100) begin
            if (busy) bc++;
            @(posedge CLK); #1;
            lat++;
        end
    endtask

    task automatic run16(input logic [2:0] f, input logic [15:0] ia, ib,
                         output int lat, output int bc);
        h_start = 1'b1; h_funct3 = f; h_a = ia; h_b = ib;
        @(posedge CLK); #1;
        h_start = 1'b0; h_a = 16'hFFFF; h_b = 16'h1234;
        lat = 0; bc = 0;
        while (!h_done && lat < 100) begin
            if (h_busy) bc++;
            @(posedge CLK); #1;
            lat++;
        end
    endtask

    // Watch a window of cycles and report whether done or busy ever went high.
    task automatic watch_quiet(input int n, output logic seen);
        seen = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (done || busy) seen = 1'b1;
            @(posedge CLK); #1;
        end
    endtask

    initial begin
        int   lat, bc;
        logic seen;

        RESET = 1'b0; start = 1'b0; flush = 1'b0; funct3 = 3'b000; a = 32'h0; b = 32'h0;
        h_start = 1'b0; h_flush = 1'b0; h_funct3 = 3'b000; h_a = 16'h0; h_b = 16'h0;

        vq.push_back(mk(3'b000, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 1'b0, 34));
        vq.push_back(mk(3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0, 1'b0, 34));
        vq.push_back(mk(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 34));
        vq.push_back(mk(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1'b0, 34));
        vq.push_back(mk(3'b100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 1'b0, 1'b0, 34));
        vq.push_back(mk(3'b110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 1'b0, 1'b0, 34));
        vq.push_back(mk(3'b101, 32'd100,      32'd7,        32'd14,       1'b0, 1'b0, 34));
        vq.push_back(mk(3'b111, 32'd100,      32'd7,        32'd2,        1'b0, 1'b0, 34));
        vq.push_back(mk(3'b101, 32'd13,       32'd0,        32'hFFFFFFFF, 1'b1, 1'b0, 1));
        vq.push_back(mk(3'b110, 32'd13,       32'd0,        32'd13,       1'b1, 1'b0, 1));
        vq.push_back(mk(3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b1, 1));
        vq.push_back(mk(3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1, 1));
        vq.push_back(mk(3'b101, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0, 34));
        vq.push_back(mk(3'b111, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b0, 34));
        vq.push_back(mk(3'b100, 32'h80000000, 32'h00000002, 32'hC0000000, 1'b0, 1'b0, 34));
        vq.push_back(mk(3'b001, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 1'b0, 1'b0, 34));
        vq.push_back(mk(3'b011, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 1'b0, 1'b0, 34));
        vq.push_back(mk(3'b100, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, 1'b0, 34));
        vq.push_back(mk(3'b110, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0, 34));
        vq.push_back(mk(3'b100, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b1, 1'b0, 1));
        vq.push_back(mk(3'b111, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 1));
        vq.push_back(mk(3'b000, 32'h12345678, 32'h00000010, 32'h23456780, 1'b0, 1'b0, 34));

        repeat (3) @(posedge CLK);
        #1;
        check("reset outputs32", {busy, done, zero_division, overflow_signed_div, result},
              {4'b0000, 32'h0});
        check("reset outputs16", {h_busy, h_done, h_zd, h_ov, h_result}, {4'b0000, 16'h0});
        @(negedge CLK); RESET = 1'b1;
        @(posedge CLK); #1;

        // Each vector after the first is issued in the previous one's done cycle.
        foreach (vq[i]) begin
            run32(vq[i].f, vq[i].a, vq[i].b, lat, bc);
            check($sformatf("v%0d result", i), result, vq[i].res);
            check($sformatf("v%0d flags", i), {zero_division, overflow_signed_div},
                  {vq[i].zd, vq[i].ov});
            check($sformatf("v%0d latency", i), lat, vq[i].lat);
            check($sformatf("v%0d busy cycles", i), bc, (vq[i].lat == 1) ? 0 : 34);
            check($sformatf("v%0d busy at done", i), busy, 1'b0);
        end
        @(posedge CLK); #1;
        check("idle after done", {busy, done}, 2'b00);

        // Start pulsed mid-run is ignored; the original DIVU completes unchanged.
        start = 1'b1; funct3 = 3'b101; a = 32'd100; b = 32'd7;
        @(posedge CLK); #1;
        start = 1'b0;
        lat = 0;
        while (!done && lat < 100) begin
            start = (lat == 5); funct3 = 3'b000; a = 32'd3; b = 32'd3;
            @(posedge CLK); #1;
            lat++;
        end
        start = 1'b0;
        check("ignored start latency", lat, 34);
        check("ignored start result", result, 32'd14);
        @(posedge CLK); #1;

        // Flush at cycle 10 of a DIV: no done, result and flags untouched.
        start = 1'b1; funct3 = 3'b100; a = 32'hFFFFFFF9; b = 32'd2;
        @(posedge CLK); #1;
        start = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            start = (c == 5);
            flush = (c == 10);
            @(posedge CLK); #1;
        end
        start = 1'b0; flush = 1'b0;
        check("flush busy/done", {busy, done}, 2'b00);
        check("flush result held", {zero_division, overflow_signed_div, result},
              {2'b00, 32'd14});
        watch_quiet(40, seen);
        check("flush no later done", seen, 1'b0);

        // Flush together with start in IDLE blocks the accept.
        start = 1'b1; flush = 1'b1; funct3 = 3'b000; a = 32'd5; b = 32'd5;
        @(posedge CLK); #1;
        start = 1'b0; flush = 1'b0;
        watch_quiet(40, seen);
        check("flush+start not accepted", seen, 1'b0);
        check("flush+start result", result, 32'd14);

        // Asynchronous reset mid-operation clears everything immediately.
        start = 1'b1; funct3 = 3'b100; a = 32'hFFFFFFF9; b = 32'd2;
        @(posedge CLK); #1;
        start = 1'b0;
        repeat (10) @(posedge CLK);
        #2;
        RESET = 1'b0;
        #1;
        check("mid-op reset", {busy, done, zero_division, overflow_signed_div, result},
              {4'b0000, 32'h0});
        @(negedge CLK); RESET = 1'b1;
        @(posedge CLK); #1;
        watch_quiet(40, seen);
        check("no done after reset", seen, 1'b0);

        // XLEN=16: MUL then MULHU issued in the MUL's done cycle.
        run16(3'b000, 16'h0100, 16'h0100, lat, bc);
        check("x16 mul result", h_result, 16'h0000);
        check("x16 mul latency", lat, 18);
        check("x16 mul busy cycles", bc, 18);
        run16(3'b011, 16'h0100, 16'h0100, lat, bc);
        check("x16 mulhu result", h_result, 16'h0001);
        check("x16 mulhu latency", lat, 18);
        check("x16 mulhu flags", {h_zd, h_ov, h_busy}, 3'b000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
